// File: rtl/ets_sweep_ctrl.sv
// rtl/ets_sweep_ctrl.sv - equivalent-time-sampling sweep engine driving the MMCM fine phase shift
// Define ETS_REWIND_EN to walk the phase back to its start value after the last beat.
module ets_sweep_ctrl #(
   parameter int N_CH     = 4,
   parameter int STEP_W   = 10,
   parameter int AVG_LOG2 = 8,
   parameter int SETTLE   = 16,
   parameter int PS_TMO   = 1024,
   localparam int CNT_W   = AVG_LOG2 + 1
) (
   input  logic                    free_run_clk,
   input  logic                    free_run_rst,
   input  logic                    start,
   input  logic [STEP_W-1:0]       n_steps,
   input  logic [N_CH-1:0]         sample_in,
   input  logic                    locked,
   output logic                    ps_en,
   output logic                    ps_incdec,
   input  logic                    ps_done,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [N_CH*CNT_W-1:0]   m_data,
   output logic [STEP_W-1:0]       m_step,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [STEP_W-1:0]       phase_pos
);

   localparam int N_AVG   = 2 ** AVG_LOG2;
   localparam int MAX_AS  = (N_AVG > SETTLE) ? N_AVG : SETTLE;
   localparam int TMR_MAX = (PS_TMO > MAX_AS) ? PS_TMO : MAX_AS;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ACCUM,
      S_EMIT,
      S_STEP,
      S_WAITPS,
`ifdef ETS_REWIND_EN
      S_REWIND,
`endif
      S_FIN
   } state_t;

   state_t                       state, state_nxt;
   state_t                       after_last, after_ps;
   logic [TMR_W-1:0]             tmr;
   logic [N_CH-1:0][CNT_W-1:0]   cnt;
   logic [STEP_W-1:0]            k, n_lat, last_k;
   logic                         is_last, rewinding, abort;

   assign last_k  = n_lat - 1'b1;
   assign is_last = (k == last_k);

`ifdef ETS_REWIND_EN
   logic [STEP_W-1:0] rew_cnt;

   // Forward WAITPS never has k at the last step, so that marks the rewind phase.
   assign rewinding  = is_last;
   assign after_last = (n_lat == STEP_W'(1)) ? S_FIN : S_REWIND;
   assign after_ps   = rewinding ? ((rew_cnt == STEP_W'(1)) ? S_FIN : S_REWIND) : S_SETTLE;
`else
   assign rewinding  = 1'b0;
   assign after_last = S_FIN;
   assign after_ps   = S_SETTLE;
`endif

   assign abort = (state != S_IDLE) &&
                  (!locked || (state == S_WAITPS && !ps_done && tmr == TMR_W'(PS_TMO - 1)));

   always_ff @(posedge free_run_clk) begin
      if (free_run_rst) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start && n_steps != '0) state_nxt = S_SETTLE;
         S_SETTLE: if (tmr == TMR_W'(SETTLE - 1)) state_nxt = S_ACCUM;
         S_ACCUM:  if (tmr == TMR_W'(N_AVG - 1)) state_nxt = S_EMIT;
         S_EMIT:   if (m_ready) state_nxt = is_last ? after_last : S_STEP;
         S_STEP:   state_nxt = S_WAITPS;
         S_WAITPS: if (ps_done) state_nxt = after_ps;
`ifdef ETS_REWIND_EN
         S_REWIND: state_nxt = S_WAITPS;
`endif
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_comb begin
      ps_en     = 1'b0;
      ps_incdec = 1'b0;
      m_valid   = 1'b0;
      m_data    = '0;
      m_step    = '0;
      m_last    = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_STEP: begin
            ps_en     = 1'b1;
            ps_incdec = 1'b1;
         end
`ifdef ETS_REWIND_EN
         S_REWIND: ps_en = 1'b1;
`endif
         S_EMIT: begin
            m_valid = 1'b1;
            m_data  = cnt;
            m_step  = k;
            m_last  = is_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge free_run_clk) begin
      if (free_run_rst) begin
         tmr       <= '0;
         cnt       <= '0;
         k         <= '0;
         n_lat     <= '0;
         phase_pos <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         // One timer serves settle, accumulate and ps_done timeout: it restarts on every state change.
         tmr  <= (state_nxt != state) ? '0 : tmr + 1'b1;
         if (state == S_IDLE && start) begin
            err   <= 1'b0;
            n_lat <= n_steps;
            k     <= '0;
            if (n_steps == '0) done <= 1'b1;
         end
         if (state == S_SETTLE && state_nxt == S_ACCUM) cnt <= '0;
         if (state == S_ACCUM) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt[i] + CNT_W'(sample_in[i]);
         end
         if (state == S_WAITPS && ps_done && !abort) begin
            if (rewinding) begin
               phase_pos <= phase_pos - 1'b1;
            end else begin
               phase_pos <= phase_pos + 1'b1;
               k         <= k + 1'b1;
            end
         end
         if (state == S_FIN) done <= 1'b1;
         if (abort) begin
            err  <= 1'b1;
            done <= 1'b1;
         end
      end
   end

`ifdef ETS_REWIND_EN
   always_ff @(posedge free_run_clk) begin
      if (free_run_rst) begin
         rew_cnt <= '0;
      end else if (state == S_EMIT && m_ready && is_last) begin
         rew_cnt <= last_k;
      end else if (state == S_WAITPS && ps_done && rewinding) begin
         rew_cnt <= rew_cnt - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// tb/tb_ets_sweep_ctrl.sv - randomized self-checking bench for ets_sweep_ctrl
module tb_ets_sweep_ctrl;

   localparam int N_CH     = 4;
   localparam int STEP_W   = 10;
   localparam int AVG_LOG2 = 8;
   localparam int SETTLE   = 16;
   localparam int PS_TMO   = 1024;
   localparam int CNT_W    = AVG_LOG2 + 1;
   localparam int N_AVG    = 1 << AVG_LOG2;
`ifdef ETS_REWIND_EN
   localparam bit REW = 1'b1;
`else
   localparam bit REW = 1'b0;
`endif

   logic                   free_run_clk = 1'b0;
   logic                   free_run_rst = 1'b1;
   logic                   start = 1'b0;
   logic [STEP_W-1:0]      n_steps = '0;
   logic [N_CH-1:0]        sample_in = '0;
   logic                   locked = 1'b1;
   logic                   ps_en, ps_incdec;
   logic                   ps_done = 1'b0;
   logic                   m_valid;
   logic                   m_ready = 1'b1;
   logic [N_CH*CNT_W-1:0]  m_data;
   logic [STEP_W-1:0]      m_step;
   logic                   m_last, busy, done, err;
   logic [STEP_W-1:0]      phase_pos;

   always #5 free_run_clk = ~free_run_clk;

   ets_sweep_ctrl #(
      .N_CH(N_CH), .STEP_W(STEP_W), .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .PS_TMO(PS_TMO)
   ) dut (
      .free_run_clk(free_run_clk), .free_run_rst(free_run_rst), .start(start),
      .n_steps(n_steps), .sample_in(sample_in), .locked(locked),
      .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_step(m_step),
      .m_last(m_last), .busy(busy), .done(done), .err(err), .phase_pos(phase_pos)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // stimulus knobs
   int              samp_mode = 0;
   logic [N_CH-1:0] samp_const = '0;
   int              rdy_mode = 0;
   int              ps_delay = 3;
   bit              ps_hold = 1'b0;
   int              exp_n = 0;
   int              start_cyc = 0;
   int              model_phase = 0;

   int              cyc = 0;
   int              valid_run = 0;
   logic [N_CH-1:0] hist[$];

   always @(posedge free_run_clk) begin
      cyc++;
      hist.push_back(sample_in);
      if (hist.size() > N_AVG + 8) void'(hist.pop_front());
      #1;
      sample_in = (samp_mode != 0) ? N_CH'($urandom) : samp_const;
      valid_run = m_valid ? valid_run + 1 : 0;
      case (rdy_mode)
         1:       m_ready = 1'($urandom_range(0, 1));
         2:       m_ready = (valid_run > 50);
         default: m_ready = 1'b1;
      endcase
   end

   // MMCM model: acknowledges each phase-shift request ps_delay cycles later
   always begin
      @(negedge free_run_clk);
      if (ps_en && !ps_hold && !free_run_rst) begin
         repeat (ps_delay) @(posedge free_run_clk);
         #1 ps_done = 1'b1;
         @(posedge free_run_clk);
         #1 ps_done = 1'b0;
      end
   end

   // Expected hit counts: per-channel sum of the samples in the averaging window just before the beat.
   function automatic logic [63:0] model_counts();
      logic [63:0] r;
      int base;
      r = '0;
      base = hist.size() - N_AVG;
      for (int c = 0; c < N_CH; c++) begin
         int s;
         s = 0;
         for (int j = 0; j < N_AVG; j++) s += int'(hist[base + j][c]);
         r |= 64'(s) << (c * CNT_W);
      end
      return r;
   endfunction

   int          n_beats = 0, n_inc = 0, n_dec = 0, n_done = 0;
   int          exp_k = 0, first_valid_cyc = 0, last_psen_cyc = 0, done_cyc = 0;
   bit          in_beat = 1'b0, pend = 1'b0;
   logic [63:0] exp_data = '0;

   always @(negedge free_run_clk) begin
      if (free_run_rst) begin
         in_beat = 1'b0;
         pend    = 1'b0;
         exp_k   = 0;
      end else begin
         if (!busy) exp_k = 0;
         if (ps_en) begin
            last_psen_cyc = cyc;
            if (ps_incdec) n_inc++;
            else           n_dec++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (pend) check("valid_hold", m_valid, 1'b1);
         if (m_valid) begin
            if (!in_beat) begin
               in_beat  = 1'b1;
               exp_data = model_counts();
               if (exp_k == 0) first_valid_cyc = cyc;
            end
            check("m_data", m_data, exp_data);
            check("m_step", m_step, exp_k);
            check("m_last", m_last, exp_k == exp_n - 1);
            if (m_ready) begin
               in_beat = 1'b0;
               exp_k++;
               n_beats++;
            end
         end
         pend = m_valid && !m_ready;
      end
   end

   task automatic pulse_start(input int n);
      @(posedge free_run_clk); #1;
      n_steps   = STEP_W'(n);
      start     = 1'b1;
      exp_n     = n;
      start_cyc = cyc;
      @(posedge free_run_clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge free_run_clk); #1;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, ok, 1'b1);
   endtask

   task automatic wait_psen(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge free_run_clk); #1;
         if (ps_en) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_psen_seen"}, ok, 1'b1);
   endtask

   int b0, i0, d0, dn0;

   task automatic snap();
      b0 = n_beats; i0 = n_inc; d0 = n_dec; dn0 = n_done;
   endtask

   task automatic sweep_end(input string tag, input int n);
      wait_done(tag, 20000);
      if (n > 0 && !REW) model_phase += n - 1;
      check({tag, "_beats"}, n_beats - b0, n);
      check({tag, "_inc"}, n_inc - i0, (n > 0) ? n - 1 : 0);
      check({tag, "_dec"}, n_dec - d0, (REW && n > 0) ? n - 1 : 0);
      check({tag, "_phase"}, phase_pos, STEP_W'(model_phase));
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      @(negedge free_run_clk); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_done_cnt"}, n_done - dn0, 1);
   endtask

   task automatic sweep(input string tag, input int n);
      snap();
      pulse_start(n);
      sweep_end(tag, n);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {ps_en, ps_incdec, m_valid, m_data, m_step, m_last, busy, done, err, phase_pos}, '0);
   endtask

   initial begin
      free_run_rst = 1'b1;
      repeat (4) @(posedge free_run_clk);
      #1;
      check_outputs_zero("reset_outputs");
      free_run_rst = 1'b0;

      // constant pattern, three steps, ready always high
      samp_mode  = 0;
      samp_const = 4'b0101;
      rdy_mode   = 0;
      ps_delay   = 3;
      snap();
      pulse_start(3);
      sweep_end("t1", 3);
      check("t1_latency", first_valid_cyc - start_cyc, SETTLE + N_AVG + 1);
      check("t1_last_counts", exp_data, {27'd0, 9'd0, 9'd256, 9'd0, 9'd256});

      // single step and empty sweep
      sweep("t2_one", 1);
      snap();
      pulse_start(0);
      check("t2_zero_done_next", done, 1'b1);
      sweep_end("t2_zero", 0);

      // stalled sink and a start pulse in mid-sweep
      samp_mode = 1;
      rdy_mode  = 2;
      snap();
      pulse_start(3);
      repeat (100) @(posedge free_run_clk);
      #1;
      n_steps = 7;
      start   = 1'b1;
      @(posedge free_run_clk); #1;
      start = 1'b0;
      sweep_end("t3", 3);
      rdy_mode = 0;

      // ps_done withheld: timeout abort
      ps_hold = 1'b1;
      snap();
      pulse_start(3);
      wait_psen("t4_tmo");
      wait_done("t4_tmo", PS_TMO + 100);
      check("t4_tmo_time", done_cyc - last_psen_cyc, PS_TMO + 1);
      check("t4_tmo_err", err, 1'b1);
      check("t4_tmo_busy", busy, 1'b0);
      check("t4_tmo_beats", n_beats - b0, 1);
      check("t4_tmo_phase", phase_pos, STEP_W'(model_phase));
      ps_hold = 1'b0;
      sweep("t4_clear", 1);

      // lock lost during accumulation
      snap();
      pulse_start(2);
      repeat (SETTLE + 40) @(posedge free_run_clk);
      #1 locked = 1'b0;
      @(posedge free_run_clk);
      #1 locked = 1'b1;
      wait_done("t4_lock", 50);
      check("t4_lock_err", err, 1'b1);
      check("t4_lock_beats", n_beats - b0, 0);
      check("t4_lock_valid", m_valid, 1'b0);

      // five steps: rewind or not
      rdy_mode = 1;
      ps_delay = 2;
      sweep("t5", 5);

      // reset while waiting for ps_done
      ps_hold = 1'b1;
      pulse_start(3);
      wait_psen("t6");
      repeat (3) @(posedge free_run_clk);
      #1 free_run_rst = 1'b1;
      @(posedge free_run_clk); #1;
      check_outputs_zero("t6_reset_outputs");
      free_run_rst = 1'b0;
      model_phase  = 0;
      ps_hold      = 1'b0;
      sweep("t6_after", 2);

      // randomized sweeps
      for (int it = 0; it < 4; it++) begin
         samp_mode = 1;
         rdy_mode  = $urandom_range(0, 1);
         ps_delay  = $urandom_range(1, 6);
         sweep("rnd", $urandom_range(1, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
